tail_light_monitor: RTL and testbench
=====================================

Name: tail_light_monitor

Overview:
- Receive-side checker for the tail-light lamp bus {la,lb,lc,ra,rb,rc} driven by carFSM.
- Samples the six lamp lines every clock and tracks the sequence with its own FSM. Reports the current mode, counts completed sweeps and flags illegal or mis-ordered patterns.
- Sits beside carFSM in the integration bench and on-chip as a lamp-driver self-check.

Parameters:
- CNT_W, 8: width of sweep_count; the counter saturates at 2^CNT_W-1.
- STALL_MAX, 4: maximum number of consecutive edges a non-zero pattern may be sampled unchanged.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = in reset).
- la, lb, lc, input, 1 each: left lamps, la innermost.
- ra, rb, rc, input, 1 each: right lamps, ra innermost.
- clear_err, input, 1: synchronous clear of err/err_code.
- mode, output, 2: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- sweep_done, output, 1: one-cycle pulse when a sweep completes.
- sweep_count, output, CNT_W: number of completed sweeps, saturating.
- err, output, 1: sticky error flag.
- err_code, output, 2: 0 none, 1 ILLEGAL, 2 BAD_SEQ, 3 STALL.

Behaviour:
- Pattern P = {la,lb,lc,ra,rb,rc}. Legal patterns:
  - IDLE = 000000
  - L1 = 100000, L2 = 110000, L3 = 111000
  - R1 = 000100, R2 = 000110, R3 = 000111
  - HZ = 111111 (see Optional Feature)
- FSM states: S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ.
- Legal transitions:
  - S_IDLE -> S_L1, S_R1 or S_HZ.
  - S_L1 -> S_L2 -> S_L3 -> S_IDLE; S_R1 -> S_R2 -> S_R3 -> S_IDLE; S_HZ -> S_IDLE.
  - Any state may hold its own pattern (stall rule applies). S_IDLE may hold indefinitely.
- Resync: a legal pattern arriving out of order sets BAD_SEQ and the FSM jumps to that pattern's state. An illegal pattern sets ILLEGAL and the FSM goes to S_IDLE.
- Stall: a counter counts consecutive edges on which the same non-zero P is sampled. When the count exceeds STALL_MAX, STALL is set once and the counter holds. The counter clears on any change of P.
- Latency: all outputs are registered. The response to P sampled at edge N is visible after edge N.
- mode is decoded from the state register: S_L* = LEFT, S_R* = RIGHT, S_HZ = HAZARD, S_IDLE = IDLE.
- Sweep completion: sampling 000000 in S_L3, S_R3 or S_HZ gives sweep_done=1 for exactly one cycle and increments sweep_count, saturating at max.
- Aborted sweeps do not count. An abort is 000000 sampled in S_L1, S_L2, S_R1 or S_R2; it is BAD_SEQ with no sweep_done.
- Error priority in one cycle: ILLEGAL > BAD_SEQ > STALL.
- err_code captures the first error only and holds until clear_err. If clear_err and a new error coincide, the new error is captured (err=1).
- Reset, including mid-sweep, immediately forces: state S_IDLE, mode 0, sweep_done 0, sweep_count 0, err 0, err_code 0, stall counter 0.

Optional Feature:
- Macro TAIL_MON_HAZARD_EN.
- Defined: 111111 is legal, S_HZ exists, and HAZARD sweeps count.
- Undefined: 111111 is classified ILLEGAL, mode never equals 3, and S_HZ is not synthesised.

Decomposition:
- tail_light_pkg holds:
  - mode_t enum (IDLE/LEFT/RIGHT/HAZARD)
  - err_code_t enum (NONE/ILLEGAL/BAD_SEQ/STALL)
  - state_t enum
  - the 6-bit pattern constants (PAT_IDLE, PAT_L1..PAT_L3, PAT_R1..PAT_R3, PAT_HZ)
- One sub-module, tail_light_pattern_decode: purely combinational classification of P into a pattern id plus a legal flag. Hazard legality is gated by the same macro.

Test Plan:
- Reset low, then high; drive 000000 for 5 cycles -> mode=0, sweep_done=0, sweep_count=0, err=0 throughout.
- 100000, 110000, 111000, 000000, one per cycle -> mode=1 after the first edge; sweep_done pulses once after the 000000 edge; sweep_count=1; err=0. Repeat with 000100, 000110, 000111 -> mode=2, count=2.
- From IDLE drive 100000, 111000 -> err=1, err_code=2 (BAD_SEQ), FSM in S_L3 (mode=1); then 000000 -> sweep_done pulses, count+1.
- Drive 101010 -> err_code=1, mode=0; pulse clear_err -> err=0. Drive clear_err with 010000 in the same cycle -> err stays 1, err_code=1.
- Hold 110000 for 6 edges with STALL_MAX=4 -> err_code=3 asserted after the 5th edge. Separately, with CNT_W=2, run 5 full sweeps -> sweep_count=3 (saturated).
- Assert reset mid-sweep (state S_R2) -> all outputs 0 asynchronously. Run a 111111, 000000 pair twice: with TAIL_MON_HAZARD_EN -> mode=3 and sweep_done pulses; without it -> err_code=1.

Source files
------------

// File: rtl/tail_light_pkg.sv
// -----------------------------------------------------------------------------
// tail_light_pkg
// Shared types and constants for the tail-light lamp-bus monitor.
//   mode_t      : decoded sweep direction reported to the outside world
//   err_code_t  : first-error classification
//   state_t     : monitor FSM states; also used as the pattern id
//   PAT_*       : 6-bit lamp patterns, bit order {la,lb,lc,ra,rb,rc}
// Optional feature macro: TAIL_MON_HAZARD_EN (hazard pattern 111111 legal).
// -----------------------------------------------------------------------------
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_BAD_SEQ = 2'd2,
    ERR_STALL   = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HZ   = 3'd7
  } state_t;

  localparam logic [5:0] PAT_IDLE = 6'b000000;
  localparam logic [5:0] PAT_L1   = 6'b100000;
  localparam logic [5:0] PAT_L2   = 6'b110000;
  localparam logic [5:0] PAT_L3   = 6'b111000;
  localparam logic [5:0] PAT_R1   = 6'b000100;
  localparam logic [5:0] PAT_R2   = 6'b000110;
  localparam logic [5:0] PAT_R3   = 6'b000111;
  localparam logic [5:0] PAT_HZ   = 6'b111111;

  // True when moving from cur to nxt is the in-order step of a sweep.
  // Holding the current state is not a step and is handled separately.
  function automatic logic is_successor(input state_t cur, input state_t nxt);
    logic ok;
    ok = 1'b0;
    case (cur)
      S_IDLE: ok = (nxt == S_L1) || (nxt == S_R1) || (nxt == S_HZ);
      S_L1:   ok = (nxt == S_L2);
      S_L2:   ok = (nxt == S_L3);
      S_R1:   ok = (nxt == S_R2);
      S_R2:   ok = (nxt == S_R3);
      S_L3,
      S_R3,
      S_HZ:   ok = (nxt == S_IDLE);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State to externally visible mode.
  function automatic mode_t mode_of(input state_t s);
    mode_t m;
    m = MODE_IDLE;
    case (s)
      S_L1, S_L2, S_L3: m = MODE_LEFT;
      S_R1, S_R2, S_R3: m = MODE_RIGHT;
`ifdef TAIL_MON_HAZARD_EN
      S_HZ:             m = MODE_HAZARD;
`else
      S_HZ:             m = MODE_IDLE;
`endif
      default:          m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tail_light_monitor_if.sv
// -----------------------------------------------------------------------------
// tail_light_monitor_if
// Lamp bus plus monitor status bundle.
//   master : lamp driver side (drives la..rc and clear_err, observes status)
//   slave  : monitor side (samples lamps, drives mode/sweep/error status)
// Signals:
//   la,lb,lc    left lamps, la innermost
//   ra,rb,rc    right lamps, ra innermost
//   clear_err   synchronous clear of err/err_code
//   mode        0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD
//   sweep_done  one-cycle pulse per completed sweep
//   sweep_count saturating sweep counter, CNT_W bits
//   err         sticky error flag
//   err_code    first captured error
//   dbg_state   live FSM state for checkers
// Handshake: there is no valid/ready pair; the lamp lines are sampled on every
// rising clock edge and every status output is a registered value that is
// valid on every cycle after that edge.
// -----------------------------------------------------------------------------
interface tail_light_monitor_if #(
  parameter int CNT_W = 8
) ();
  import tail_light_pkg::*;

  logic             la;
  logic             lb;
  logic             lc;
  logic             ra;
  logic             rb;
  logic             rc;
  logic             clear_err;
  mode_t            mode;
  logic             sweep_done;
  logic [CNT_W-1:0] sweep_count;
  logic             err;
  err_code_t        err_code;
  state_t           dbg_state;

  modport master (
    output la, lb, lc, ra, rb, rc, clear_err,
    input  mode, sweep_done, sweep_count, err, err_code, dbg_state
  );

  modport slave (
    input  la, lb, lc, ra, rb, rc, clear_err,
    output mode, sweep_done, sweep_count, err, err_code, dbg_state
  );
endinterface

// File: rtl/tail_light_pattern_decode.sv
// -----------------------------------------------------------------------------
// tail_light_pattern_decode
// Purely combinational classification of a lamp pattern.
// Ports:
//   pat     in  6  {la,lb,lc,ra,rb,rc}
//   pat_id  out    state the pattern belongs to (S_IDLE when illegal)
//   legal   out 1  pattern is one of the recognised lamp patterns
// Optional feature macro: TAIL_MON_HAZARD_EN. Without it 111111 is illegal.
// -----------------------------------------------------------------------------
module tail_light_pattern_decode
  import tail_light_pkg::*;
(
  input  logic [5:0] pat,
  output state_t     pat_id,
  output logic       legal
);

  always_comb begin
    pat_id = S_IDLE;
    legal  = 1'b1;
    case (pat)
      PAT_IDLE: pat_id = S_IDLE;
      PAT_L1:   pat_id = S_L1;
      PAT_L2:   pat_id = S_L2;
      PAT_L3:   pat_id = S_L3;
      PAT_R1:   pat_id = S_R1;
      PAT_R2:   pat_id = S_R2;
      PAT_R3:   pat_id = S_R3;
`ifdef TAIL_MON_HAZARD_EN
      PAT_HZ:   pat_id = S_HZ;
`endif
      default:  legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/tail_light_monitor.sv
// -----------------------------------------------------------------------------
// tail_light_monitor
// Receive-side checker for the tail-light lamp bus. Samples the six lamp
// lines every clock, follows the sweep sequence with its own FSM, reports the
// current mode, counts completed sweeps and flags illegal, out-of-order or
// stalled patterns.
// Ports:
//   clk    in 1  rising-edge clock
//   reset  in 1  asynchronous active-low reset (0 = in reset)
//   bus    slave modport of tail_light_monitor_if (lamps in, status out)
// Parameters:
//   CNT_W      width of sweep_count (saturating)
//   STALL_MAX  max consecutive edges a non-zero pattern may be seen unchanged
// Optional feature macro: TAIL_MON_HAZARD_EN (hazard 111111 sweeps).
// -----------------------------------------------------------------------------
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tail_light_monitor_if.slave  bus
);

  // Counter must be able to reach STALL_MAX+1 and sit there.
  localparam int STALL_W = $clog2(STALL_MAX + 2);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);

  logic [5:0] pat;
  state_t     pat_id;
  logic       pat_legal;

  assign pat = {bus.la, bus.lb, bus.lc, bus.ra, bus.rb, bus.rc};

  tail_light_pattern_decode u_decode (
    .pat    (pat),
    .pat_id (pat_id),
    .legal  (pat_legal)
  );

  // Registered state and outputs
  state_t           state;
  logic [5:0]       last_pat;
  logic [STALL_W-1:0] stall_cnt;
  mode_t            mode_q;
  logic             sweep_done_q;
  logic [CNT_W-1:0] sweep_count_q;
  logic             err_q;
  err_code_t        err_code_q;

  // Next-cycle decisions
  state_t             next_state;
  logic               ev_illegal;
  logic               ev_bad_seq;
  logic               ev_stall;
  logic               sweep_evt;
  logic               same_pat;
  logic [STALL_W-1:0] stall_cnt_next;
  err_code_t          ev_code;

  always_comb begin
    next_state     = S_IDLE;
    ev_illegal     = 1'b0;
    ev_bad_seq     = 1'b0;
    ev_stall       = 1'b0;
    sweep_evt      = 1'b0;
    same_pat       = 1'b0;
    stall_cnt_next = '0;
    ev_code        = ERR_NONE;

    if (!pat_legal) begin
      ev_illegal = 1'b1;
      next_state = S_IDLE;
    end else begin
      // Hold, in-order step and resync all land in the pattern's own state;
      // only the error and sweep flags differ.
      next_state = pat_id;
      if (pat_id != state) begin
        if (is_successor(state, pat_id)) begin
          // The only successor equal to S_IDLE is the end of a full sweep.
          sweep_evt = (pat_id == S_IDLE);
        end else begin
          ev_bad_seq = 1'b1;
        end
      end
    end

    // Stall run length of an unchanged non-zero pattern. The first edge of a
    // new pattern counts as 1; the event fires on the edge where the run
    // first exceeds STALL_MAX, after which the counter parks.
    same_pat = (|pat) && (pat == last_pat);
    if (!same_pat) begin
      stall_cnt_next = (|pat) ? STALL_W'(1) : '0;
    end else if (stall_cnt > STALL_LIMIT) begin
      stall_cnt_next = stall_cnt;
    end else begin
      stall_cnt_next = stall_cnt + 1'b1;
      ev_stall       = (stall_cnt == STALL_LIMIT);
    end

    if (ev_illegal) begin
      ev_code = ERR_ILLEGAL;
    end else if (ev_bad_seq) begin
      ev_code = ERR_BAD_SEQ;
    end else if (ev_stall) begin
      ev_code = ERR_STALL;
    end else begin
      ev_code = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      last_pat      <= PAT_IDLE;
      stall_cnt     <= '0;
      mode_q        <= MODE_IDLE;
      sweep_done_q  <= 1'b0;
      sweep_count_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state        <= next_state;
      last_pat     <= pat;
      stall_cnt    <= stall_cnt_next;
      mode_q       <= mode_of(next_state);
      sweep_done_q <= sweep_evt;

      if (sweep_evt && !(&sweep_count_q)) begin
        sweep_count_q <= sweep_count_q + 1'b1;
      end

      // First error sticks. A clear in the same cycle as a new error lets the
      // new error through so it is never lost.
      if (bus.clear_err) begin
        err_q      <= (ev_code != ERR_NONE);
        err_code_q <= ev_code;
      end else if (!err_q && (ev_code != ERR_NONE)) begin
        err_q      <= 1'b1;
        err_code_q <= ev_code;
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.sweep_done  = sweep_done_q;
  assign bus.sweep_count = sweep_count_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_tail_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_tail_light_monitor
// Scoreboarded bench for tail_light_monitor. Two instances share one lamp bus:
// CNT_W=8 and CNT_W=2 (the latter exercises counter saturation). A reference
// model built from sweep lists predicts every cycle's outputs; a monitor pops
// one prediction per clock edge and compares.
// Honours TAIL_MON_HAZARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_tail_light_monitor;
  import tail_light_pkg::*;

  localparam int STALL_MAX = 4;
  localparam int EW = 16;
  typedef logic [5:0] pat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tail_light_monitor_if #(.CNT_W(8)) bus8 ();
  tail_light_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus2.la        = bus8.la;
  assign bus2.lb        = bus8.lb;
  assign bus2.lc        = bus8.lc;
  assign bus2.ra        = bus8.ra;
  assign bus2.rb        = bus8.rb;
  assign bus2.rc        = bus8.rc;
  assign bus2.clear_err = bus8.clear_err;

  tail_light_monitor #(.CNT_W(8), .STALL_MAX(STALL_MAX)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  tail_light_monitor #(.CNT_W(2), .STALL_MAX(STALL_MAX)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // ---------------- reference model ----------------
  // Sweeps as ordered lists: 0 = left, 1 = right, 2 = hazard.
  pat_t sw [3][3];
  int   sw_len [3];

  pat_t m_cur;
  pat_t m_last;
  int   m_run;
  int   m_count;
  logic m_done;
  logic m_err;
  int   m_code;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic void locate(input pat_t p, output int w, output int i);
    w = -1;
    i = -1;
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < sw_len[a]; b++)
        if (sw[a][b] == p) begin
          w = a;
          i = b;
        end
  endfunction

  // Pattern that legitimately follows cur within its sweep (0 after the last).
  function automatic logic follows(input pat_t cur, input pat_t nxt);
    int w, i;
    if (cur == 6'd0) begin
      locate(nxt, w, i);
      return (w >= 0) && (i == 0);
    end
    locate(cur, w, i);
    if (i == sw_len[w] - 1) return nxt == 6'd0;
    return nxt == sw[w][i+1];
  endfunction

  function automatic int mode_exp(input pat_t cur);
    int w, i;
    locate(cur, w, i);
    return w + 1;
  endfunction

  function automatic logic [EW-1:0] pack_exp();
    logic [7:0] c8;
    logic [1:0] c2;
    logic [1:0] md;
    c8 = (m_count > 255) ? 8'd255 : 8'(m_count);
    c2 = (m_count > 3) ? 2'd3 : 2'(m_count);
    md = 2'(mode_exp(m_cur));
    return {md, m_done, c8, m_err, 2'(m_code), c2};
  endfunction

  task automatic model_reset();
    m_cur   = 6'd0;
    m_last  = 6'd0;
    m_run   = 0;
    m_count = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_code  = 0;
  endtask

  task automatic model_update(input pat_t p, input logic clr);
    int w, i, code;
    logic illegal, bad_seq, stall;
    locate(p, w, i);
    illegal = (p != 6'd0) && (w < 0);
    bad_seq = 1'b0;
    m_done  = 1'b0;
    if (illegal) begin
      m_cur = 6'd0;
    end else if (p != m_cur) begin
      if (follows(m_cur, p)) m_done = (p == 6'd0);
      else bad_seq = 1'b1;
      m_cur = p;
    end
    if (p != 6'd0 && p == m_last) m_run++;
    else m_run = (p != 6'd0) ? 1 : 0;
    stall  = (m_run == STALL_MAX + 1);
    m_last = p;
    code = illegal ? 1 : bad_seq ? 2 : stall ? 3 : 0;
    if (clr) begin
      m_err  = (code != 0);
      m_code = code;
    end else if (!m_err && code != 0) begin
      m_err  = 1'b1;
      m_code = code;
    end
    if (m_done) m_count++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input pat_t p, input logic clr, input logic rst_v);
    @(negedge clk);
    reset = rst_v;
    {bus8.la, bus8.lb, bus8.lc, bus8.ra, bus8.rb, bus8.rc} = p;
    bus8.clear_err = clr;
    if (!rst_v) model_reset();
    else model_update(p, clr);
    exp_q.push_back(pack_exp());
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for clk.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_mode", 32'(bus8.mode), 0);
    chk("async_done", 32'(bus8.sweep_done), 0);
    chk("async_count", 32'(bus8.sweep_count), 0);
    chk("async_err", 32'(bus8.err), 0);
    chk("async_code", 32'(bus8.err_code), 0);
    chk("async_count2", 32'(bus2.sweep_count), 0);
    model_reset();
  endtask

  task automatic sweep(input int w);
    for (int i = 0; i < sw_len[w]; i++) step(sw[w][i], 1'b0, 1'b1);
    step(6'd0, 1'b0, 1'b1);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mode", 32'(bus8.mode), 32'(e[15:14]));
        chk("sweep_done", 32'(bus8.sweep_done), 32'(e[13]));
        chk("sweep_count", 32'(bus8.sweep_count), 32'(e[12:5]));
        chk("err", 32'(bus8.err), 32'(e[4]));
        chk("err_code", 32'(bus8.err_code), 32'(e[3:2]));
        chk("sweep_count_w2", 32'(bus2.sweep_count), 32'(e[1:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    pat_t p;
    int r, w, i;
    logic hz_en;
    hz_en = 1'b0;
`ifdef TAIL_MON_HAZARD_EN
    hz_en = 1'b1;
`endif
    sw[0] = '{6'b100000, 6'b110000, 6'b111000};
    for (int k = 0; k < 3; k++) sw[1][k] = sw[0][k] >> 3;  // right mirrors left
    sw[2] = '{6'b111111, 6'b000000, 6'b000000};
    sw_len[0] = 3;
    sw_len[1] = 3;
    sw_len[2] = hz_en ? 1 : 0;
    model_reset();
    bus8.clear_err = 1'b0;
    {bus8.la, bus8.lb, bus8.lc, bus8.ra, bus8.rb, bus8.rc} = 6'd0;

    // Reset, then idle.
    repeat (3) step(6'd0, 1'b0, 1'b0);
    repeat (5) step(6'd0, 1'b0, 1'b1);

    // Clean left then right sweep.
    sweep(0);
    sweep(1);

    // Skip L2: bad sequence, resync into L3, sweep still completes.
    step(6'b100000, 1'b0, 1'b1);
    step(6'b111000, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1);

    // Illegal pattern, clear, then clear coinciding with a new error.
    step(6'b000000, 1'b1, 1'b1);
    step(6'b101010, 1'b0, 1'b1);
    step(6'b000000, 1'b1, 1'b1);
    step(6'b010000, 1'b1, 1'b1);
    step(6'b000000, 1'b0, 1'b1);
    step(6'b000000, 1'b1, 1'b1);

    // Stall: hold L2 for six edges, then finish the sweep.
    step(6'b100000, 1'b0, 1'b1);
    repeat (6) step(6'b110000, 1'b0, 1'b1);
    step(6'b111000, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1);
    step(6'b000000, 1'b1, 1'b1);

    // Abort mid-sweep (no count), then five sweeps to saturate the 2-bit count.
    step(6'b000100, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1);
    step(6'b000000, 1'b1, 1'b1);
    repeat (5) sweep(0);

    // Reset while in S_R2.
    step(6'b000100, 1'b0, 1'b1);
    step(6'b000110, 1'b0, 1'b1);
    async_reset_check();
    step(6'd0, 1'b0, 1'b0);
    step(6'd0, 1'b0, 1'b1);

    // Hazard pair twice (legal or illegal depending on the build).
    repeat (2) begin
      step(6'b111111, 1'b0, 1'b1);
      step(6'b000000, 1'b0, 1'b1);
    end
    step(6'b000000, 1'b1, 1'b1);

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        if (m_cur == 6'd0) begin
          p = sw[$urandom_range(0, hz_en ? 2 : 1)][0];
        end else begin
          locate(m_cur, w, i);
          p = (i == sw_len[w] - 1) ? 6'd0 : sw[w][i+1];
        end
      end else if (r < 75) begin
        p = m_cur;
      end else if (r < 90) begin
        i = $urandom_range(0, 7);
        p = (i == 0) ? 6'd0 : (i == 7) ? 6'b111111 : sw[(i-1)/3][(i-1)%3];
      end else begin
        p = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 249) == 0) begin
        async_reset_check();
        step(6'd0, 1'b0, 1'b0);
      end else begin
        step(p, ($urandom_range(0, 19) == 0), 1'b1);
      end
    end

    step(6'd0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
